// File: rtl/uop_seq.sv
// uop_seq: microcode sequencer with a writable store and a registered issue stage.
//
// Each unstalled cycle the word at upc is read combinationally, captured into the issue
// register together with upc, and the next upc is chosen from the word's sequencing fields:
// decoder dispatch (BRINST), last, next, jump, conditional jump on SR.T, call/return and
// counted loops. ex_stall_i freezes all sequencer state; store writes are never blocked.
//
// Optional feature macro: UOPSEQ_CALLSTK_EN
//   defined   -> STK_DEPTH-entry call stack, CALL/RET push/pop, sticky stk_err_o on misuse
//   undefined -> no stack, CALL acts as JMP, RET acts as last, stk_err_o tied low
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   pgm_wr_en_i/addr_i/data_i     microcode store write port
//   entry_valid_i, entry_pc_i     decoder dispatch request
//   entry_ack_o                   registered pulse: dispatch entry consumed
//   sr_t_i                        SR.T flag for JT/JF
//   ex_stall_i                    execute back-pressure, freezes the sequencer
//   uop_valid_o/word_o/pc_o       issue register
//   stk_err_o                     sticky call-stack overflow/underflow
module uop_seq #(
    parameter int unsigned UPC_BITS  = 12,
    parameter int unsigned UOP_BITS  = 32,
    parameter int unsigned STK_DEPTH = 4,
    parameter int unsigned LOOP_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pgm_wr_en_i,
    input  logic [UPC_BITS-1:0] pgm_wr_addr_i,
    input  logic [UOP_BITS-1:0] pgm_wr_data_i,
    input  logic                entry_valid_i,
    input  logic [UPC_BITS-1:0] entry_pc_i,
    output logic                entry_ack_o,
    input  logic                sr_t_i,
    input  logic                ex_stall_i,
    output logic                uop_valid_o,
    output logic [UOP_BITS-1:0] uop_word_o,
    output logic [UPC_BITS-1:0] uop_pc_o,
    output logic                stk_err_o
);

    localparam int unsigned Depth = 2 ** UPC_BITS;

    typedef enum logic [2:0] {
        SeqNext   = 3'd0,
        SeqJmp    = 3'd1,
        SeqJt     = 3'd2,
        SeqJf     = 3'd3,
        SeqCall   = 3'd4,
        SeqRet    = 3'd5,
        SeqLdloop = 3'd6,
        SeqLoop   = 3'd7
    } seq_op_e;

    // Microcode store: no reset, so a program survives core resets.
    logic [UOP_BITS-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (pgm_wr_en_i) begin
            mem_q[pgm_wr_addr_i] <= pgm_wr_data_i;
        end
    end

    logic [UPC_BITS-1:0]  upc_q, upc_d;
    logic [LOOP_BITS-1:0] loop_q, loop_d;
    logic                 valid_q, valid_d;
    logic [UOP_BITS-1:0]  word_q, word_d;
    logic [UPC_BITS-1:0]  pc_q, pc_d;
    logic                 ack_q, ack_d;

    logic [UOP_BITS-1:0]  fetch_w;
    logic                 is_brinst;
    logic                 is_last;
    seq_op_e              seq_op;
    logic [UPC_BITS-1:0]  target;
    logic [LOOP_BITS-1:0] count;
    logic [UPC_BITS-1:0]  upc_inc;

    assign fetch_w   = mem_q[upc_q];
    assign is_brinst = (fetch_w[31:24] == 8'h00);
    assign is_last   = fetch_w[23];
    assign seq_op    = seq_op_e'(fetch_w[22:20]);
    assign target    = fetch_w[UPC_BITS-1:0];
    assign count     = fetch_w[LOOP_BITS-1:0];
    assign upc_inc   = upc_q + UPC_BITS'(1);

    // Field bits above the used target/count width are deliberately ignored.
    logic unused_fetch;
    assign unused_fetch = ^fetch_w;

`ifdef UOPSEQ_CALLSTK_EN
    localparam int unsigned SpBits = $clog2(STK_DEPTH + 1);

    logic [UPC_BITS-1:0] stk_q [STK_DEPTH];
    logic [SpBits-1:0]   sp_q, sp_d;
    logic                err_q, err_d;
    logic                push;
    logic                stk_full;
    logic                stk_empty;
    logic [UPC_BITS-1:0] stk_top;

    assign stk_full  = (sp_q == SpBits'(STK_DEPTH));
    assign stk_empty = (sp_q == '0);

    // sp_q points at the next free slot; the top of stack lives at sp_q - 1.
    always_comb begin
        stk_top = '0;
        for (int i = 0; i < int'(STK_DEPTH); i++) begin
            if (SpBits'(i) == (sp_q - SpBits'(1))) begin
                stk_top = stk_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(STK_DEPTH); i++) begin
                stk_q[i] <= '0;
            end
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (push) begin
                for (int i = 0; i < int'(STK_DEPTH); i++) begin
                    if (SpBits'(i) == sp_q) begin
                        stk_q[i] <= upc_inc;
                    end
                end
            end
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign stk_err_o = err_q;
`else
    assign stk_err_o = 1'b0;
`endif

    always_comb begin
        upc_d   = upc_q;
        loop_d  = loop_q;
        valid_d = valid_q;
        word_d  = word_q;
        pc_d    = pc_q;
        ack_d   = 1'b0;
`ifdef UOPSEQ_CALLSTK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
`endif
        if (!ex_stall_i) begin
            word_d  = fetch_w;
            pc_d    = upc_q;
            valid_d = 1'b1;
            if (is_brinst) begin
                // Wait on the BRINST until the decoder offers an entry; bubbles meanwhile.
                if (entry_valid_i) begin
                    upc_d = entry_pc_i;
                    ack_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (is_last) begin
                upc_d = '0;
            end else begin
                unique case (seq_op)
                    SeqNext: upc_d = upc_inc;
                    SeqJmp:  upc_d = target;
                    SeqJt:   upc_d = sr_t_i ? target : upc_inc;
                    SeqJf:   upc_d = sr_t_i ? upc_inc : target;
                    SeqCall: begin
                        upc_d = target;
`ifdef UOPSEQ_CALLSTK_EN
                        // Full stack degrades to a plain jump and flags the error.
                        if (stk_full) begin
                            err_d = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SpBits'(1);
                        end
`endif
                    end
                    SeqRet: begin
`ifdef UOPSEQ_CALLSTK_EN
                        if (stk_empty) begin
                            upc_d = '0;
                            err_d = 1'b1;
                        end else begin
                            upc_d = stk_top;
                            sp_d  = sp_q - SpBits'(1);
                        end
`else
                        upc_d = '0;
`endif
                    end
                    SeqLdloop: begin
                        loop_d = count;
                        upc_d  = upc_inc;
                    end
                    SeqLoop: begin
                        if (loop_q != '0) begin
                            loop_d = loop_q - LOOP_BITS'(1);
                            upc_d  = target;
                        end else begin
                            upc_d = upc_inc;
                        end
                    end
                    default: upc_d = upc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upc_q   <= '0;
            loop_q  <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
            pc_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            upc_q   <= upc_d;
            loop_q  <= loop_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            pc_q    <= pc_d;
            ack_q   <= ack_d;
        end
    end

    assign entry_ack_o = ack_q;
    assign uop_valid_o = valid_q;
    assign uop_word_o  = word_q;
    assign uop_pc_o    = pc_q;

endmodule

// File: tb/tb_uop_seq.sv
// tb_uop_seq: directed self-checking bench for uop_seq (UPC_BITS=8, STK_DEPTH=2).
// Expected call/return behaviour follows UOPSEQ_CALLSTK_EN as compiled.
module tb_uop_seq;

    localparam logic [2:0] SNext   = 3'd0;
    localparam logic [2:0] SJmp    = 3'd1;
    localparam logic [2:0] SJt     = 3'd2;
    localparam logic [2:0] SCall   = 3'd4;
    localparam logic [2:0] SRet    = 3'd5;
    localparam logic [2:0] SLdloop = 3'd6;
    localparam logic [2:0] SLoop   = 3'd7;
    localparam logic [7:0] OpX     = 8'h11;

    logic        clk;
    logic        rst_n;
    logic        pgm_wr_en;
    logic [7:0]  pgm_wr_addr;
    logic [31:0] pgm_wr_data;
    logic        entry_valid;
    logic [7:0]  entry_pc;
    logic        entry_ack;
    logic        sr_t;
    logic        ex_stall;
    logic        uop_valid;
    logic [31:0] uop_word;
    logic [7:0]  uop_pc;
    logic        stk_err;

    int vectors;
    int miscompares;

    uop_seq #(
        .UPC_BITS (8),
        .UOP_BITS (32),
        .STK_DEPTH(2),
        .LOOP_BITS(8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pgm_wr_en_i  (pgm_wr_en),
        .pgm_wr_addr_i(pgm_wr_addr),
        .pgm_wr_data_i(pgm_wr_data),
        .entry_valid_i(entry_valid),
        .entry_pc_i   (entry_pc),
        .entry_ack_o  (entry_ack),
        .sr_t_i       (sr_t),
        .ex_stall_i   (ex_stall),
        .uop_valid_o  (uop_valid),
        .uop_word_o   (uop_word),
        .uop_pc_o     (uop_pc),
        .stk_err_o    (stk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input logic [7:0] op, input logic lst,
                                       input logic [2:0] seq, input logic [19:0] fld);
        return {op, lst, seq, fld};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        pgm_wr_en   = 1'b1;
        pgm_wr_addr = addr;
        pgm_wr_data = data;
        step();
        pgm_wr_en   = 1'b0;
    endtask

    task automatic reset_on();
        rst_n       = 1'b0;
        entry_valid = 1'b0;
        entry_pc    = '0;
        sr_t        = 1'b0;
        ex_stall    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_pc [4];
        exp_pc = '{8'h00, 8'h01, 8'h02, 8'h00};
        reset_on();
        wr(8'h00, mk(OpX, 1'b0, SNext, 20'h0));
        wr(8'h01, mk(OpX, 1'b0, SNext, 20'h0));
        wr(8'h02, mk(OpX, 1'b1, SNext, 20'h0));
        vectors++;
        if ({uop_valid, uop_word, uop_pc, entry_ack, stk_err} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b w=%h pc=%h ack=%b err=%b expected all zero",
                     uop_valid, uop_word, uop_pc, entry_ack, stk_err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (uop_valid !== 1'b1 || uop_pc !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL reset_seq[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         i, uop_valid, uop_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_dispatch();
        reset_on();
        wr(8'h00, mk(8'h00, 1'b0, SNext, 20'h0));
        wr(8'h40, mk(OpX, 1'b0, SNext, 20'h0));
        wr(8'h41, mk(OpX, 1'b1, SNext, 20'h0));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (uop_valid !== 1'b0 || entry_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL dispatch_bubble[%0d]: got v=%b ack=%b expected v=0 ack=0",
                         i, uop_valid, entry_ack);
            end
        end
        entry_valid = 1'b1;
        entry_pc    = 8'h40;
        step();
        vectors++;
        if (uop_valid !== 1'b1 || entry_ack !== 1'b1 || uop_pc !== 8'h00
            || uop_word !== 32'h0) begin
            miscompares++;
            $display("FAIL dispatch_issue: got v=%b ack=%b pc=%h w=%h expected 1 1 00 00000000",
                     uop_valid, entry_ack, uop_pc, uop_word);
        end
        entry_valid = 1'b0;
        step();
        vectors++;
        if (uop_valid !== 1'b1 || entry_ack !== 1'b0 || uop_pc !== 8'h40) begin
            miscompares++;
            $display("FAIL dispatch_target: got v=%b ack=%b pc=%h expected v=1 ack=0 pc=40",
                     uop_valid, entry_ack, uop_pc);
        end
    endtask

    task automatic test_jt();
        logic [7:0] exp_pc [6];
        exp_pc = '{8'h00, 8'h05, 8'h20, 8'h00, 8'h05, 8'h06};
        reset_on();
        wr(8'h00, mk(OpX, 1'b0, SJmp, 20'h05));
        wr(8'h05, mk(OpX, 1'b0, SJt, 20'h20));
        wr(8'h06, mk(OpX, 1'b1, SNext, 20'h0));
        wr(8'h20, mk(OpX, 1'b1, SNext, 20'h0));
        sr_t  = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (uop_valid !== 1'b1 || uop_pc !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL jt_seq[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         i, uop_valid, uop_pc, exp_pc[i]);
            end
            if (i == 3) sr_t = 1'b0;
        end
    endtask

    task automatic test_loop();
        logic [7:0] exp_pc [8];
        exp_pc = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
        reset_on();
        wr(8'h00, mk(OpX, 1'b0, SLdloop, 20'h3));
        wr(8'h01, mk(OpX, 1'b0, SLoop, 20'h01));
        // Counter is exhausted here, so this LOOP must fall through rather than jump.
        wr(8'h02, mk(OpX, 1'b0, SLoop, 20'h30));
        wr(8'h03, mk(OpX, 1'b1, SNext, 20'h0));
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (uop_valid !== 1'b1 || uop_pc !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL loop_seq[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         i, uop_valid, uop_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] w_next;
        logic [31:0] w_new;
        w_next = mk(OpX, 1'b0, SNext, 20'h0);
        w_new  = mk(8'h22, 1'b1, SNext, 20'h0);
        reset_on();
        wr(8'h00, w_next);
        wr(8'h01, w_next);
        wr(8'h02, w_next);
        wr(8'h03, mk(OpX, 1'b1, SNext, 20'h0));
        rst_n = 1'b1;
        step();
        step();
        ex_stall    = 1'b1;
        pgm_wr_en   = 1'b1;
        pgm_wr_addr = 8'h03;
        pgm_wr_data = w_new;
        for (int i = 0; i < 4; i++) begin
            step();
            pgm_wr_en = 1'b0;
            vectors++;
            if (uop_valid !== 1'b1 || uop_pc !== 8'h01 || uop_word !== w_next) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h w=%h expected v=1 pc=01 w=%h",
                         i, uop_valid, uop_pc, uop_word, w_next);
            end
        end
        ex_stall = 1'b0;
        step();
        vectors++;
        if (uop_pc !== 8'h02) begin
            miscompares++;
            $display("FAIL stall_resume: got pc=%h expected pc=02", uop_pc);
        end
        step();
        vectors++;
        if (uop_pc !== 8'h03 || uop_word !== w_new) begin
            miscompares++;
            $display("FAIL stall_store_write: got pc=%h w=%h expected pc=03 w=%h",
                     uop_pc, uop_word, w_new);
        end
        step();
        vectors++;
        if (uop_pc !== 8'h00) begin
            miscompares++;
            $display("FAIL stall_last: got pc=%h expected pc=00", uop_pc);
        end
    endtask

    task automatic test_call();
        logic [7:0] exp_pc  [7];
        logic       exp_err [7];
`ifdef UOPSEQ_CALLSTK_EN
        exp_pc  = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h11, 8'h01, 8'h00};
        exp_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_pc  = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h00, 8'h10, 8'h20};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset_on();
        wr(8'h00, mk(OpX, 1'b0, SCall, 20'h10));
        wr(8'h10, mk(OpX, 1'b0, SCall, 20'h20));
        wr(8'h20, mk(OpX, 1'b0, SCall, 20'h30));
        wr(8'h30, mk(OpX, 1'b0, SRet, 20'h0));
        wr(8'h11, mk(OpX, 1'b0, SRet, 20'h0));
        wr(8'h01, mk(OpX, 1'b0, SRet, 20'h0));
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (uop_pc !== exp_pc[i] || stk_err !== exp_err[i]) begin
                miscompares++;
                $display("FAIL call_seq[%0d]: got pc=%h err=%b expected pc=%h err=%b",
                         i, uop_pc, stk_err, exp_pc[i], exp_err[i]);
            end
        end
    endtask

    task automatic test_reset_mid_call();
        logic exp_err;
`ifdef UOPSEQ_CALLSTK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset_on();
        wr(8'h00, mk(OpX, 1'b0, SCall, 20'h10));
        rst_n = 1'b1;
        step();
        step();
        step();
        // Asynchronous assertion between clock edges must clear outputs at once.
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({uop_valid, uop_word, uop_pc, entry_ack, stk_err} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_async: got v=%b w=%h pc=%h ack=%b err=%b expected all zero",
                     uop_valid, uop_word, uop_pc, entry_ack, stk_err);
        end
        wr(8'h00, mk(OpX, 1'b0, SRet, 20'h0));
        rst_n = 1'b1;
        step();
        vectors++;
        if (uop_valid !== 1'b1 || uop_pc !== 8'h00 || stk_err !== exp_err) begin
            miscompares++;
            $display("FAIL reset_ret_issue: got v=%b pc=%h err=%b expected v=1 pc=00 err=%b",
                     uop_valid, uop_pc, stk_err, exp_err);
        end
        step();
        vectors++;
        if (uop_pc !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_stack_empty: got pc=%h expected pc=00", uop_pc);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        pgm_wr_en   = 1'b0;
        pgm_wr_addr = '0;
        pgm_wr_data = '0;
        entry_valid = 1'b0;
        entry_pc    = '0;
        sr_t        = 1'b0;
        ex_stall    = 1'b0;
        test_reset();
        test_dispatch();
        test_jt();
        test_loop();
        test_stall();
        test_call();
        test_reset_mid_call();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uop_seq.md
# uop_seq

Parametrised microcode sequencer feeding the execute stage of the microcoded core. It holds a writable microcode store and issues one uop per cycle into a registered issue stage. It replaces the fixed 4096-entry "next or restart" stepping with jump, conditional jump on SR.T, call/return, counted loops, decoder dispatch handshake and execute back-pressure.

## Interface
- UPC_BITS, 12, microcode PC width; store depth 2^UPC_BITS; legal range 4..20
- UOP_BITS, 32, uop word width; minimum 32
- STK_DEPTH, 4, call stack entries; minimum 1
- LOOP_BITS, 8, loop counter width; maximum 20

- clk  in  1  clock; all state updates on posedge
- rstN  in  1  asynchronous active-low reset
- pgmWrEn  in  1  microcode store write strobe
- pgmWrAddr  in  UPC_BITS  store write address
- pgmWrData  in  UOP_BITS  store write data
- entryValid  in  1  decoder has a dispatch entry ready
- entryPc  in  UPC_BITS  decoder dispatch uop PC
- entryAck  out  1  one-cycle pulse: dispatch entry consumed
- srT  in  1  SR.T flag for conditional jumps
- exStall  in  1  execute stage not accepting; freezes the sequencer
- uopValid  out  1  issue register holds a real uop
- uopWord  out  UOP_BITS  issued uop
- uopPc  out  UPC_BITS  store address of issued uop
- stkErr  out  1  sticky call-stack overflow/underflow flag

## Operation
- Uop fields:
  - [31:24] execute opcode; 0x00 is BRINST
  - [23] last
  - [22:20] seqOp
  - [19:0] target or count, low bits used
- Fetch word W = store[upc] (combinational read). Issue register captures W and upc each unstalled cycle.
- Next-PC priority:
  - BRINST with entryValid: next = entryPc; entryAck=1; W issued.
  - BRINST without entryValid: upc holds; bubble issued (uopValid=0).
  - last=1: next = 0.
  - Otherwise seqOp decides:
    - 0 NEXT: upc+1, wrapping at 2^UPC_BITS.
    - 1 JMP: target.
    - 2 JT: target if srT=1, else upc+1.
    - 3 JF: target if srT=0, else upc+1.
    - 4 CALL: push upc+1, next = target.
    - 5 RET: next = pop.
    - 6 LDLOOP: loopCnt = count, next = upc+1.
    - 7 LOOP: if loopCnt≠0, decrement and jump to target; else upc+1.
- CALL with stack full: acts as JMP and sets stkErr. RET with stack empty: next = 0 and sets stkErr.
- srT is sampled in the fetch cycle. Flag hazards from the uop in the issue register are the microcode's responsibility.
- exStall=1 freezes upc, stack, loopCnt, issue register and entryAck (driven 0). It does not block store writes.
- Store writes occur on posedge. A fetch of the written address in the same cycle returns the old data. Reset does not clear the store.
- Reset values: upc=0, stack pointer=0, loopCnt=0, uopValid=0, uopWord=0, uopPc=0, entryAck=0, stkErr=0.

## Timing
- Issue latency: 1 cycle from upc to uopWord/uopPc. Throughput: 1 uop/cycle. Taken branches cost no bubble.
- entryAck is a registered pulse in the cycle the dispatched BRINST appears on uopWord. The decoder must hold entryPc stable while entryValid=1 and not acked.
- Reset asserted mid-operation clears state immediately. The first post-reset fetch is store[0] on the first posedge after rstN rises.
- stkErr is cleared only by reset.

## Configuration
- UOPSEQ_CALLSTK_EN defined: call stack of STK_DEPTH entries present, CALL/RET behave as above.
- UOPSEQ_CALLSTK_EN undefined: no stack storage. CALL behaves as JMP, RET behaves as last (next=0), stkErr tied 0.

## Test plan
- Reset, store[0..2] = NEXT/NEXT/last → uopPc issues 0,1,2,0, uopValid=1 from the first cycle after reset.
- store[0] = BRINST, entryValid low 3 cycles then high with entryPc=0x40 → 3 bubbles, then BRINST issued with entryAck=1, next uopPc=0x40.
- store[5] = JT target 0x20: srT=1 → next uopPc=0x20; srT=0 → next uopPc=6.
- LDLOOP count 3, then LOOP back to itself → LOOP uop issued 4 times, then falls through; loopCnt=0.
- With UOPSEQ_CALLSTK_EN and STK_DEPTH=2: three nested CALLs → third acts as jump, stkErr=1. Two RETs return to the correct +1 addresses; a third RET → uopPc 0.
- exStall held 4 cycles mid-sequence, and rstN pulsed mid-CALL → outputs frozen during stall, then resume. After reset: upc=0, stack empty, stkErr=0.
